// File: rtl/tx_frame_sched.sv
// Two-channel round-robin frame scheduler: serialises 16-bit codewords LSB-first,
// one bit per SYM_PERIOD cycles, with an optional idle gap after each frame.
module tx_frame_sched #(
    parameter int SYM_PERIOD = 256,
    parameter int GAP_SYMS   = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        in0_valid,
    input  logic [15:0] in0_code,
    output logic        in0_ready,
    input  logic        in1_valid,
    input  logic [15:0] in1_code,
    output logic        in1_ready,
    output logic        out_bit,
    output logic        sym_strobe,
    output logic [3:0]  bit_idx,
    output logic        tx_active,
    output logic        grant_id,
    output logic        frame_done
);

    localparam int            PW         = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SYM_PERIOD - 1);
    localparam logic [3:0]    GAP_LAST   = (GAP_SYMS > 0) ? 4'(GAP_SYMS - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state_reg,      state_next;
    logic [PW-1:0] phase_reg,      phase_next;
    logic [3:0]    bit_idx_reg,    bit_idx_next;
    logic [15:0]   shift_reg,      shift_next;
    logic          grant_reg,      grant_next;
    logic          last_grant_reg, last_grant_next;
    logic [3:0]    gap_cnt_reg,    gap_cnt_next;
    logic          frame_done_reg, frame_done_next;

    logic [1:0]    valid_vec;
    logic [1:0]    ready_vec;
    logic [15:0]   code_vec [2];
    logic          sel;
    logic          idle_ok;
    logic          xfer;
    logic          phase_end;

    assign valid_vec   = {in1_valid, in0_valid};
    assign code_vec[0] = in0_code;
    assign code_vec[1] = in1_code;

    // Contention goes to the channel that did not win last; a lone requester always wins.
    assign sel     = (valid_vec == 2'b11) ? ~last_grant_reg : in1_valid;
    assign idle_ok = (state_reg == ST_IDLE) && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign ready_vec[gi] = idle_ok && valid_vec[gi] && ((gi == 1) ? sel : !sel);
        end
    endgenerate

    assign in0_ready = ready_vec[0];
    assign in1_ready = ready_vec[1];
    assign xfer      = |ready_vec;
    assign phase_end = (phase_reg == PHASE_LAST);

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        gap_cnt_next    = gap_cnt_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    shift_next      = code_vec[sel];
                    grant_next      = sel;
                    last_grant_next = sel;
                    phase_next      = '0;
                    bit_idx_next    = 4'd0;
                    state_next      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (phase_end) begin
                    phase_next   = '0;
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx_reg + 4'd1;
                    if (bit_idx_reg == 4'd15) begin
                        frame_done_next = 1'b1;
                        gap_cnt_next    = 4'd0;
                        state_next      = (GAP_SYMS > 0) ? ST_GAP : ST_IDLE;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            ST_GAP: begin
                // The phase counter is reused to time each idle symbol of the gap.
                if (phase_end) begin
                    phase_next = '0;
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 4'd1;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= '0;
            bit_idx_reg    <= 4'd0;
            shift_reg      <= 16'd0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            gap_cnt_reg    <= 4'd0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            gap_cnt_reg    <= gap_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign tx_active  = (state_reg == ST_SEND);
    assign out_bit    = tx_active && shift_reg[0];
    assign sym_strobe = tx_active && (phase_reg == '0);
    assign bit_idx    = bit_idx_reg;
    assign grant_id   = grant_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched: two instances (SYM_PERIOD=4/GAP=1 and SYM_PERIOD=3/GAP=0)
// share stimulus and are checked every cycle against a frame-timeline model.
module tb_tx_frame_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v0, v1;
    logic [15:0] c0, c1;
    logic        o_r0 [2];
    logic        o_r1 [2];
    logic        o_bit [2];
    logic        o_str [2];
    logic        o_act [2];
    logic        o_gid [2];
    logic        o_fd [2];
    logic [3:0]  o_idx [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    // Model state: a frame is described only by its transfer cycle, codeword and channel.
    bit          busy [2];
    int          t0 [2];
    logic [15:0] mcode [2];
    bit          mgid [2];
    bit          mlast [2];

    tx_frame_sched #(.SYM_PERIOD(4), .GAP_SYMS(1)) dut_a (
        .clk_sys(clk), .reset(rst),
        .in0_valid(v0), .in0_code(c0), .in0_ready(o_r0[0]),
        .in1_valid(v1), .in1_code(c1), .in1_ready(o_r1[0]),
        .out_bit(o_bit[0]), .sym_strobe(o_str[0]), .bit_idx(o_idx[0]),
        .tx_active(o_act[0]), .grant_id(o_gid[0]), .frame_done(o_fd[0])
    );

    tx_frame_sched #(.SYM_PERIOD(3), .GAP_SYMS(0)) dut_b (
        .clk_sys(clk), .reset(rst),
        .in0_valid(v0), .in0_code(c0), .in0_ready(o_r0[1]),
        .in1_valid(v1), .in1_code(c1), .in1_ready(o_r1[1]),
        .out_bit(o_bit[1]), .sym_strobe(o_str[1]), .bit_idx(o_idx[1]),
        .tx_active(o_act[1]), .grant_id(o_gid[1]), .frame_done(o_fd[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int inst, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d cyc=%0d", nm, inst, act, exp, cyc);
        end
    endfunction

    int sp, gp, k, eidx;
    bit send, fd, idle, sel, er0, er1, ebit;

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                sp   = (i == 0) ? 4 : 3;
                gp   = (i == 0) ? 1 : 0;
                k    = cyc - t0[i] - 1;
                send = busy[i] && (k < 16 * sp);
                fd   = busy[i] && (k == 16 * sp);
                idle = !busy[i] || (k >= 16 * sp + gp * sp);
                sel  = (v0 && v1) ? !mlast[i] : v1;
                er0  = !rst && idle && v0 && !sel;
                er1  = !rst && idle && v1 && sel;
                eidx = send ? k / sp : 0;
                ebit = send ? mcode[i][eidx] : 1'b0;
                chk("in0_ready",  i, int'(o_r0[i]),  int'(er0));
                chk("in1_ready",  i, int'(o_r1[i]),  int'(er1));
                chk("out_bit",    i, int'(o_bit[i]), int'(ebit));
                chk("sym_strobe", i, int'(o_str[i]), int'(send && (k % sp == 0)));
                chk("bit_idx",    i, int'(o_idx[i]), eidx);
                chk("tx_active",  i, int'(o_act[i]), int'(send));
                chk("grant_id",   i, int'(o_gid[i]), int'(mgid[i]));
                chk("frame_done", i, int'(o_fd[i]),  int'(fd));
                if (rst) begin
                    busy[i]  = 1'b0;
                    mlast[i] = 1'b1;
                    mgid[i]  = 1'b0;
                end else if (er0 || er1) begin
                    busy[i]  = 1'b1;
                    t0[i]    = cyc;
                    mcode[i] = sel ? c1 : c0;
                    mgid[i]  = sel;
                    mlast[i] = sel;
                    $display("xfer inst=%0d ch=%0d code=%h cyc=%0d", i, sel, mcode[i], cyc);
                end
            end
        end
    end

    int          n, ta, tb2, fd_cyc, first_str, strs, r0_cnt, gcount, bit_hi;
    int          gseq [5];
    int          gcyc [5];
    bit          got, r1_seen, gsel;
    logic [15:0] cap;

    initial begin
        rst = 1'b1; v0 = 1'b1; v1 = 1'b0; c0 = 16'hA5C3; c1 = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; t0[i] = 0; mcode[i] = 16'h0; mgid[i] = 1'b0; mlast[i] = 1'b1;
        end
        @(posedge clk); #1 armed = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", 0, int'(o_r0[0]), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Lone ch0 frame of A5C3: LSB-first capture and timing of frame end and gap.
        got = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o_r0[0]) begin got = 1'b1; break; end
        end
        chk("p1_xfer", 0, int'(got), 1);
        @(posedge clk); #1 v0 = 1'b0;
        cap = 16'h0; strs = 0; r0_cnt = 0; first_str = -1; fd_cyc = -1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_r0[0]) r0_cnt++;
            if (o_str[0]) begin
                if (first_str < 0) first_str = cyc;
                strs++;
                cap[o_idx[0]] = o_bit[0];
            end
            if (o_fd[0]) begin fd_cyc = cyc; break; end
        end
        chk("p1_ready_once", 0, r0_cnt, 0);
        chk("p1_code", 0, int'(cap), 32'h0000A5C3);
        chk("p1_strobes", 0, strs, 16);
        chk("p1_fd_latency", 0, fd_cyc - first_str, 64);
        @(posedge clk); #1 v1 = 1'b1; c1 = 16'h1234;
        got = 1'b0; ta = -1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_r1[0]) begin got = 1'b1; ta = cyc; break; end
        end
        chk("p1_idle_seen", 0, int'(got), 1);
        chk("p1_gap_len", 0, ta - fd_cyc, 4);
        @(posedge clk); #1 v1 = 1'b0;

        // Both channels valid from reset: alternating grants, one cycle of IDLE per frame.
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; c0 = 16'h0001; c1 = 16'h8000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gcount = 0; bit_hi = 0;
        for (int j = 0; j < 5; j++) begin gseq[j] = -1; gcyc[j] = 0; end
        for (n = 0; n < 500 && gcount < 5; n++) begin
            @(negedge clk);
            if (gcount > 0 && o_bit[0]) bit_hi++;
            if (o_r0[0] || o_r1[0]) begin
                gseq[gcount] = int'(o_r1[0]);
                gcyc[gcount] = cyc;
                gcount++;
            end
            if (o_fd[1]) chk("b_fd_with_xfer", 1, int'(o_r0[1] | o_r1[1]), 1);
        end
        chk("p2_count", 0, gcount, 5);
        for (int j = 0; j < 4; j++) begin
            chk("p2_grant", 0, gseq[j], j % 2);
            // transfer cycle + 16 bits * 4 cycles + 1 gap symbol * 4 cycles
            chk("p2_spacing", 0, gcyc[j+1] - gcyc[j], 69);
        end
        chk("p2_bits_high", 0, bit_hi, 16);

        // Reset during bit 7, phase 2: frame aborted, ch0 wins the following contention.
        got = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_str[0] && o_idx[0] == 4'd7) begin got = 1'b1; break; end
        end
        chk("p3_find_bit7", 0, int'(got), 1);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("p3_active", 0, int'(o_act[0]), 0);
        chk("p3_bit", 0, int'(o_bit[0]), 0);
        chk("p3_no_fd", 0, int'(o_fd[0]), 0);
        chk("p3_ch0_first", 0, int'(o_r0[0]), 1);

        // ch1 pulse during SEND is ignored and leaves last_grant at ch0.
        @(posedge clk); #1 rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; v0 = 1'b1; c0 = 16'($urandom);
        ta = -1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_r0[0]) begin ta = cyc; break; end
        end
        @(posedge clk); #1 v0 = 1'b0;
        repeat (10) @(posedge clk);
        #1 v1 = 1'b1; c1 = 16'($urandom);
        @(posedge clk); #1 v1 = 1'b0; v0 = 1'b1;
        r1_seen = 1'b0; tb2 = -1000;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_r1[0]) r1_seen = 1'b1;
            if (o_r0[0]) begin tb2 = cyc; break; end
        end
        chk("p4_no_ch1", 0, int'(r1_seen), 0);
        chk("p4_first_idle", 0, tb2 - ta, 69);
        @(posedge clk); #1 v1 = 1'b1;
        got = 1'b0; gsel = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_r0[0] || o_r1[0]) begin got = 1'b1; gsel = o_r1[0]; break; end
        end
        chk("p4_seen", 0, int'(got), 1);
        chk("p4_ch1_next", 0, int'(gsel), 1);

        // Random traffic with occasional resets.
        for (int j = 0; j < 4000; j++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 399) == 0);
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 2) == 0);
            c0  = 16'($urandom);
            c1  = 16'($urandom);
        end
        @(posedge clk); #1 rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
